// File: rtl/ks_pkg.sv
// Shared mode and state encodings for the key-schedule expander.
package ks_pkg;

    typedef enum logic [1:0] {
        MODE_MIN  = 2'd0,
        MODE_FAST = 2'd1,
        MODE_FULL = 2'd2,
        MODE_RSVD = 2'd3
    } ks_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_PERM   = 3'd2,
        ST_SCAN   = 3'd3,
        ST_FINISH = 3'd4
    } ks_state_e;

endpackage

// File: rtl/ks_pair_scan.sv
// Walks word pairs (i,j), i<j<NW, i-major, one pair per cycle and flags
// whether the current pair of C words is equal and whether it is the last pair.
module ks_pair_scan #(
    parameter int CWIDTH = 128,
    parameter int WORD_W = 32,
    parameter int NW     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [CWIDTH-1:0] i_c,
    output logic              o_match,
    output logic              o_last
);

    localparam int IW = $clog2(NW + 1);
    localparam logic [IW-1:0] LAST_I = IW'(NW - 2);
    localparam logic [IW-1:0] LAST_J = IW'(NW - 1);

    logic [IW-1:0]     r_i;
    logic [IW-1:0]     r_j;
    logic [WORD_W-1:0] w_word_i;
    logic [WORD_W-1:0] w_word_j;

    // Pair counters: reload to (0,1) on start, then advance until the last pair is reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i <= '0;
            r_j <= '0;
        end else if (i_start) begin
            r_i <= '0;
            r_j <= IW'(1);
        end else if (o_last) begin
            r_i <= r_i;
            r_j <= r_j;
        end else if (r_j == LAST_J) begin
            r_i <= r_i + IW'(1);
            r_j <= r_i + IW'(2);
        end else begin
            r_i <= r_i;
            r_j <= r_j + IW'(1);
        end
    end

    // Word select and equality compare for the current pair.
    always_comb begin
        w_word_i = i_c[int'(r_i)*WORD_W +: WORD_W];
        w_word_j = i_c[int'(r_j)*WORD_W +: WORD_W];
        o_match  = (w_word_i == w_word_j);
        o_last   = (r_i == LAST_I) && (r_j == LAST_J);
    end

endmodule

// File: rtl/ks_expand.sv
// Key expansion controller: builds C/X from a key in FULL, FAST or MIN mode,
// iterating an external permutation in MIN mode until the checked words of C are distinct.
module ks_expand
    import ks_pkg::*;
#(
    parameter int MINWIDTH_K = 128,
    parameter int CWIDTH     = 128,
    parameter int XWIDTH     = 64,
    parameter int WORD_W     = 32,
    parameter int MAX_ITER   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CWIDTH+XWIDTH-1:0] k,
    input  logic [1:0]               kWidth,
    output logic                     perm_req,
    output logic [CWIDTH-1:0]        perm_c,
    input  logic                     perm_ack,
    input  logic [CWIDTH-1:0]        perm_cin,
    output logic [CWIDTH-1:0]        cout,
    output logic [XWIDTH-1:0]        xout,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int KWIDTHMAX = CWIDTH + XWIDTH;
    localparam int XWORDS    = XWIDTH / WORD_W;
    localparam int NW        = XWORDS + 1;
    localparam int CWORDS    = CWIDTH / WORD_W;
    localparam int KWORDS    = MINWIDTH_K / WORD_W;
    localparam int FW        = $clog2(CWORDS + 1);
    localparam int ITW       = $clog2(MAX_ITER + 1);

    ks_state_e             r_state;
    ks_state_e             w_state_nxt;
    ks_mode_e              r_mode;
    logic [KWIDTHMAX-1:0]  r_k;
    logic [CWIDTH-1:0]     r_c;
    logic [CWIDTH-1:0]     r_cout;
    logic [XWIDTH-1:0]     r_xout;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_perm_req;
    logic [FW-1:0]         r_fill;
    logic [ITW-1:0]        r_iter;
    logic [CWIDTH-1:0]     w_c_fill;
    logic                  w_fill_last;
    logic                  w_iter_max;
    logic                  w_scan_start;
    logic                  w_match;
    logic                  w_last;

    ks_pair_scan #(
        .CWIDTH (CWIDTH),
        .WORD_W (WORD_W),
        .NW     (NW)
    ) u_pair_scan (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_scan_start),
        .i_c     (r_c),
        .o_match (w_match),
        .o_last  (w_last)
    );

    // Fill datapath: C with the current word replaced by the cyclically repeated key word.
    always_comb begin
        w_c_fill = r_c;
        w_c_fill[int'(r_fill)*WORD_W +: WORD_W] = r_k[(int'(r_fill) % KWORDS)*WORD_W +: WORD_W];
        w_fill_last  = (r_fill == FW'(CWORDS - 1));
        w_iter_max   = (r_iter == ITW'(MAX_ITER));
        w_scan_start = (r_state == ST_PERM) && perm_ack;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if ((kWidth == MODE_FULL) || (kWidth == MODE_RSVD)) begin
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (w_fill_last) begin
                    w_state_nxt = (r_mode == MODE_FAST) ? ST_FINISH : ST_PERM;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_PERM: begin
                w_state_nxt = perm_ack ? ST_SCAN : ST_PERM;
            end
            ST_SCAN: begin
                if (w_match) begin
                    w_state_nxt = w_iter_max ? ST_FINISH : ST_PERM;
                end else if (w_last) begin
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; perm_req tracks residency in PERM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode     <= MODE_MIN;
            r_k        <= '0;
            r_c        <= '0;
            r_cout     <= '0;
            r_xout     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_perm_req <= 1'b0;
            r_fill     <= '0;
            r_iter     <= '0;
        end else begin
            r_perm_req <= (w_state_nxt == ST_PERM);
            r_done     <= (r_state == ST_FINISH);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_k    <= k;
                        r_mode <= ks_mode_e'(kWidth);
                        r_busy <= 1'b1;
                        r_err  <= (kWidth == MODE_RSVD);
                        r_fill <= '0;
                        r_iter <= '0;
                        if (kWidth == MODE_FULL) begin
                            r_cout <= k[CWIDTH-1:0];
                            r_xout <= k[KWIDTHMAX-1:CWIDTH];
                        end
                    end
                end
                ST_FILL: begin
                    r_c    <= w_c_fill;
                    r_fill <= r_fill + FW'(1);
                    if (w_fill_last && (r_mode == MODE_FAST)) begin
                        r_cout <= w_c_fill;
                        r_xout <= r_k[MINWIDTH_K+XWIDTH-1:MINWIDTH_K];
                    end
                end
                ST_PERM: begin
                    if (perm_ack) begin
                        r_c    <= perm_cin;
                        r_iter <= r_iter + ITW'(1);
                    end
                end
                ST_SCAN: begin
                    if (w_match) begin
                        if (w_iter_max) begin
                            r_err <= 1'b1;
                        end
                    end else if (w_last) begin
                        r_xout <= r_c[XWIDTH-1:0];
                        r_cout <= {r_c[CWIDTH-1:XWIDTH], r_k[XWIDTH-1:0]};
                    end
                end
                ST_FINISH: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign perm_req = r_perm_req;
    assign perm_c   = r_c;
    assign cout     = r_cout;
    assign xout     = r_xout;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: doc/ks_expand.md
KS_EXPAND -- requirements
Module: ks_expand

Interface
REQ-001 SHALL have parameter MINWIDTH_K, default 128: bit width of a MIN-mode key.
REQ-002 SHALL have parameter CWIDTH, default 128: width of the state C.
REQ-003 SHALL have parameter XWIDTH, default 64: width of X.
REQ-004 SHALL have parameter WORD_W, default 32: compare/fill word width; must divide MINWIDTH_K, CWIDTH and XWIDTH.
REQ-005 SHALL have parameter MAX_ITER, default 16: permutation-call limit before error.
REQ-006 SHALL derive KWIDTHMAX = CWIDTH+XWIDTH, XWORDS = XWIDTH/WORD_W and NW = XWORDS+1 (words checked).
REQ-007 SHALL have port clk, input, 1 bit: clock.
REQ-008 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-009 SHALL have port start, input, 1 bit: one-cycle pulse that begins an expansion; honoured only in IDLE.
REQ-010 SHALL have port k, input, KWIDTHMAX bits: key, sampled on the start cycle.
REQ-011 SHALL have port kWidth, input, 2 bits: mode, 0=MIN, 1=FAST, 2=FULL, 3=reserved; sampled on start.
REQ-012 SHALL have port perm_req, output, 1 bit: request to the external permutation.
REQ-013 SHALL have port perm_c, output, CWIDTH bits: permutation input, valid while perm_req is high.
REQ-014 SHALL have port perm_ack, input, 1 bit: single-cycle acknowledge that perm_cin is valid.
REQ-015 SHALL have port perm_cin, input, CWIDTH bits: permutation result.
REQ-016 SHALL have port cout, output, CWIDTH bits: expanded C.
REQ-017 SHALL have port xout, output, XWIDTH bits: expanded X.
REQ-018 SHALL have port busy, output, 1 bit: high from start acceptance until done.
REQ-019 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-020 SHALL have port err, output, 1 bit: sticky error flag, cleared on the next accepted start.

Function
REQ-021 SHALL implement states IDLE, FILL, PERM, SCAN, FINISH, all registered; all outputs SHALL be registered.
REQ-022 IDLE + start: latch k and kWidth, set busy, clear err; a start seen while busy SHALL be ignored.
REQ-023 FULL: IDLE->FINISH, with cout=k[CWIDTH-1:0] and xout=k[KWIDTHMAX-1:CWIDTH]; done SHALL pulse 2 cycles after the start cycle.
REQ-024 FILL: one word per cycle, C word w = k word (w mod MINWIDTH_K/WORD_W), for CWIDTH/WORD_W cycles.
REQ-025 FAST after FILL: xout=k[MINWIDTH_K+XWIDTH-1:MINWIDTH_K], cout=C, then go to FINISH.
REQ-026 MIN after FILL: go to PERM.
REQ-027 PERM: drive perm_req=1 with perm_c=C, holding both stable until perm_ack.
REQ-028 PERM on perm_ack: C<=perm_cin, drop perm_req the next cycle, increment iteration count, go to SCAN.
REQ-029 SCAN: compare one word pair (i,j) per cycle, 0<=i<j<NW, in i-major order; pair count = NW*(NW-1)/2 (3 for defaults).
REQ-030 SCAN: on the first equal pair, abort the scan and go to PERM next cycle; if the iteration count equals MAX_ITER, instead set err, leave cout/xout unchanged and go to FINISH.
REQ-031 SCAN: on no match, xout=C[XWIDTH-1:0], cout = C with [XWIDTH-1:0] replaced by k[XWIDTH-1:0], then go to FINISH.
REQ-032 FINISH: pulse done for 1 cycle, clear busy, return to IDLE; cout/xout SHALL hold until the next result.
REQ-033 Reserved kWidth: go to FINISH with err=1 and cout/xout unchanged.
REQ-034 perm_ack outside PERM SHALL be ignored.

Reset
REQ-035 reset SHALL force IDLE and set cout, xout, busy, done, err, perm_req, the counters and C to 0, at any time including mid-PERM; no done pulse SHALL follow.

Structure
REQ-036 Package ks_pkg SHALL hold the mode enum (MIN/FAST/FULL/RSVD) and the state enum.
REQ-037 Sub-module ks_pair_scan SHALL hold the pair (i,j) counters and the comparator, with interface start/C/match/last.

Verification
REQ-038 FULL, k=192'hAAAA..._1111...: cout=k[127:0] and xout=k[191:128] two cycles after start; perm_req never asserted.
REQ-039 FAST, k[191:128]=64'hDEAD_BEEF_0123_4567: xout equals that value, cout=k[127:0], no perm_req.
REQ-040 MIN, model returns words 1,2,3,4 after 3 cycles: exactly one perm_req, cout[63:0]=k[63:0], xout=64'h00000002_00000001.
REQ-041 MIN, model returns all-zero words first, then distinct words: exactly 2 perm_req handshakes, then done.
REQ-042 MIN, model always returns zeros: err=1 with done after exactly MAX_ITER=16 acks.
REQ-043 reset asserted mid-PERM, then a FULL start: busy and perm_req drop immediately, and the FULL result is correct.
